// File: rtl/wide_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_if
//  Description : Bus bundle for the word-serial wide adder. Carries the
//                start handshake, latched operands and the completion
//                result and flags.
//                  master : drives start/a_in/b_in/cin (and abort), observes
//                           busy/done/sum_out/cout/ovf
//                  slave  : the sequencer side
//                Optional abort signal exists only when WIDE_ADD_ABORT_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface wide_add_if #(
    parameter int WORDS = 4
) ();
    logic                   start;
    logic [32*WORDS-1:0]    a_in;
    logic [32*WORDS-1:0]    b_in;
    logic                   cin;
    logic                   busy;
    logic                   done;
    logic [32*WORDS-1:0]    sum_out;
    logic                   cout;
    logic                   ovf;
`ifdef WIDE_ADD_ABORT_EN
    logic                   abort;
`endif

    modport master (
`ifdef WIDE_ADD_ABORT_EN
        output abort,
`endif
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout, ovf
    );

    modport slave (
`ifdef WIDE_ADD_ABORT_EN
        input  abort,
`endif
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer (plus helper cla_adder)
//  Description : Word-serial 32*WORDS-bit adder. Operands are latched on an
//                accepted start, then one 32-bit slice per cycle is pushed
//                through a single 32-bit carry-lookahead adder with the
//                carry chained through a register. Completion raises a
//                one-cycle done pulse with unsigned carry-out and signed
//                overflow flags.
//  Ports       : clk      rising-edge clock
//                rst      asynchronous active-high reset
//                bus      wide_add_if.slave (start/a_in/b_in/cin in,
//                         busy/done/sum_out/cout/ovf out, abort optional)
//  Parameters  : WORDS    number of 32-bit slices, 2..16
//  Options     : WIDE_ADD_ABORT_EN  adds bus.abort, which returns the
//                sequencer to IDLE and clears all outputs from ADD/DONE
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cla_adder : 32-bit carry-lookahead adder built from eight 4-bit groups.
// Within a group every carry is a flat sum-of-products of the group carry-in;
// group carry-out uses group generate/propagate terms.
// ----------------------------------------------------------------------------
module cla_adder (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_cin,
    output logic      [31:0] o_s,
    output logic             o_cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;
    logic [32:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_group
            assign w_gg[k] = w_g[4*k+3]
                           | (w_p[4*k+3] & w_g[4*k+2])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            assign w_gp[k] = &w_p[4*k+3:4*k];
        end
    endgenerate

    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
    end

    assign o_s    = w_p ^ w_c[31:0];
    assign o_cout = w_c[32];
endmodule

// ----------------------------------------------------------------------------
// wide_add_sequencer
// ----------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wide_add_if.slave   bus
);
    localparam int W     = 32 * WORDS;
    localparam int MSB   = W - 1;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic [31:0]        w_sa;
    logic [31:0]        w_sb;
    logic [31:0]        w_s;
    logic               w_co;
    logic               w_last;
    logic               w_abort;
    logic               w_accept;

`ifdef WIDE_ADD_ABORT_EN
    // Abort only matters once an operation is underway.
    assign w_abort = bus.abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_last   = (r_idx == IDX_W'(WORDS - 1));
    assign w_accept = bus.start && !w_abort &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

    // Slice currently being added; operands come from the latched copies so
    // a_in/b_in may change freely mid-operation.
    assign w_sa = r_a[r_idx*32 +: 32];
    assign w_sb = r_b[r_idx*32 +: 32];

    cla_adder u_cla (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_ADD;
            S_ADD:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = bus.start ? S_ADD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_abort) begin
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // sum_out is left alone; its slices get overwritten in order.
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_idx   <= '0;
            r_carry <= bus.cin;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_sum[r_idx*32 +: 32] <= w_s;
            r_carry               <= w_co;
            r_idx                 <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                // Signed overflow: like-signed operands, result sign differs.
                r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_s[31] != r_a[MSB]);
            end
        end
    end

    assign bus.busy    = (r_state == S_ADD);
    assign bus.done    = (r_state == S_DONE);
    assign bus.sum_out = r_sum;
    assign bus.cout    = r_cout;
    assign bus.ovf     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Directed self-checking bench for wide_add_sequencer with
//                WORDS=4. Abort scenarios are included when
//                WIDE_ADD_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wide_add_sequencer;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    wide_add_if #(.WORDS(WORDS)) bus ();

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Start one operation and wait for done; lat counts edges from the
    // accepting edge (inclusive) to the edge after which done is seen.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          input logic c, output int lat);
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int           lat;
        logic [14:0]  dm;
        logic [14:0]  bm;
        logic         saw_done;
        logic [127:0] held;

        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
`ifdef WIDE_ADD_ABORT_EN
        bus.abort = 1'b0;
`endif
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum",  bus.sum_out, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf",  bus.ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Inter-slice carry
        run_op(128'hFFFF_FFFF, 128'h1, 1'b0, lat);
        chk("carry_lat",  lat, 5);
        chk("carry_sum",  bus.sum_out, 128'h1_0000_0000);
        chk("carry_cout", bus.cout, 0);
        chk("carry_ovf",  bus.ovf, 0);
        chk("carry_busy", bus.busy, 0);
        held = bus.sum_out;
        @(posedge clk); #1;
        chk("hold_sum",  bus.sum_out, 128'h1_0000_0000);
        chk("done_once", bus.done, 0);

        // Full wrap
        run_op({128{1'b1}}, 128'h1, 1'b0, lat);
        chk("wrap_sum",  bus.sum_out, 0);
        chk("wrap_cout", bus.cout, 1);
        chk("wrap_ovf",  bus.ovf, 0);

        // Carry-in only
        run_op(128'h0, 128'h0, 1'b1, lat);
        chk("cin_sum",  bus.sum_out, 128'h1);
        chk("cin_cout", bus.cout, 0);

        // Positive overflow
        run_op({1'b0, {127{1'b1}}}, 128'h1, 1'b0, lat);
        chk("povf_sum",  bus.sum_out, {1'b1, 127'b0});
        chk("povf_ovf",  bus.ovf, 1);
        chk("povf_cout", bus.cout, 0);

        // Negative overflow with carry
        run_op({1'b1, 127'b0}, {1'b1, 127'b0}, 1'b0, lat);
        chk("novf_sum",  bus.sum_out, 0);
        chk("novf_ovf",  bus.ovf, 1);
        chk("novf_cout", bus.cout, 1);

        // Mid-op start ignored, operands latched, flags cleared on accept
        @(negedge clk);
        bus.a_in  = 128'h10;
        bus.b_in  = 128'h20;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("clr_cout", bus.cout, 0);
        chk("clr_ovf",  bus.ovf, 0);
        chk("hs_busy",  bus.busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        bus.a_in  = 128'h1000;
        bus.b_in  = 128'h1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hs_lat", lat, 5);
        chk("hs_sum", bus.sum_out, 128'h30);
        @(posedge clk); #1;
        chk("hs_idle", bus.busy, 0);

        // Back-to-back with start held high
        @(negedge clk);
        bus.a_in  = 128'h1;
        bus.b_in  = 128'h2;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            dm[k] = bus.done;
            bm[k] = bus.busy;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done", dm, 15'h4210);
        chk("b2b_busy", bm, 15'h3DEF);
        chk("b2b_sum",  bus.sum_out, 128'h3);
        @(posedge clk); #1;

        // Asynchronous reset during the second ADD cycle
        @(negedge clk);
        bus.a_in  = 128'h1234;
        bus.b_in  = 128'h1111;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_sum",  bus.sum_out, 0);
        chk("mrst_cout", bus.cout, 0);
        chk("mrst_ovf",  bus.ovf, 0);
        saw_done = bus.done;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            saw_done = saw_done | bus.done;
        end
        chk("mrst_nodone", saw_done, 0);
        run_op(128'h5, 128'h3, 1'b0, lat);
        chk("post_lat", lat, 5);
        chk("post_sum", bus.sum_out, 128'h8);

`ifdef WIDE_ADD_ABORT_EN
        // Abort in the third ADD cycle
        @(negedge clk);
        bus.a_in  = 128'h55;
        bus.b_in  = 128'h11;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        chk("ab_sum",  bus.sum_out, 0);
        chk("ab_cout", bus.cout, 0);
        chk("ab_ovf",  bus.ovf, 0);
        @(negedge clk);
        bus.abort = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            saw_done = saw_done | bus.done;
        end
        chk("ab_nodone", saw_done, 0);

        // Abort beats start in DONE
        run_op({1'b1, 127'b0}, {1'b1, 127'b0}, 1'b0, lat);
        chk("ab2_pre", bus.done, 1);
        @(negedge clk);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.a_in  = 128'h7;
        bus.b_in  = 128'h7;
        @(posedge clk); #1;
        chk("ab2_busy", bus.busy, 0);
        chk("ab2_done", bus.done, 0);
        chk("ab2_sum",  bus.sum_out, 0);
        chk("ab2_ovf",  bus.ovf, 0);
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("ab2_idle", bus.busy, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word adder front end that drives a single 32-bit `cla_adder` instance word-serially, producing a `32*WORDS`-bit sum from one 32-bit carry-lookahead datapath. It sits directly upstream of `cla_adder`:
- it latches wide operands;
- it feeds one 32-bit slice per cycle with the carry chained through a register;
- it collects the slice sums.

A start/busy/done handshake sequences each operation, and flags are reported on completion.

## Interface
Parameters:
- `WORDS`, default 4: number of 32-bit slices. Legal range is 2..16. Total operand width is `32*WORDS`.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin operation. Sampled on the rising edge.
- `a_in`  input  `32*WORDS`  operand A. Latched when start is accepted.
- `b_in`  input  `32*WORDS`  operand B. Latched when start is accepted.
- `cin`  input  1  carry-in to slice 0. Latched when start is accepted.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle completion pulse.
- `sum_out`  output  `32*WORDS`  result. Held until the next accepted start.
- `cout`  output  1  carry out of the top slice.
- `ovf`  output  1  two's-complement overflow of the full-width add.
- `abort`  input  1  present only when `WIDE_ADD_ABORT_EN` is defined (see Configuration).

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - `start`=1 at an edge latches `a_in`, `b_in` and `cin`.
  - It clears the slice index to 0 and the carry register to `cin`, and moves to ADD.
- ADD, slice index `i`:
  - `cla_adder` receives `A[32i+31:32i]`, `B[32i+31:32i]` and the carry register.
  - Each edge writes `S` into `sum_out[32i+31:32i]`, loads `Cout` into the carry register, and increments `i`.
  - On the edge that writes slice `WORDS-1`:
    - `cout` <= `Cout`.
    - `ovf` <= (A msb == B msb) && (S msb != A msb), using bit 31 of the top slice.
    - The FSM moves to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - The next edge returns to IDLE. If `start`=1 on that edge, a new operation is accepted and the FSM goes directly to ADD.
- `start` is ignored while in ADD. Latched operands are unaffected by changes on `a_in`/`b_in` mid-operation.
- `sum_out` slices update progressively during ADD. They are only valid when `done`=1, and stay stable afterwards.
- Accepting a new start clears `cout` and `ovf` to 0. `sum_out` is not cleared; its slices are overwritten in order.
- Arithmetic is unsigned modulo `2^(32*WORDS)`. `cout` is the unsigned carry and `ovf` is the signed overflow; the two are independent.

## Timing
- Reset (asynchronous, immediate): state IDLE, `busy`=0, `done`=0, `sum_out`=0, `cout`=0, `ovf`=0, index 0, carry register 0.
- Latency: start is accepted at edge E0. `busy`=1 from E0 through E`WORDS`. `done`=1 between E`WORDS` and E`WORDS+1`.
- Total latency is `WORDS`+1 cycles start-to-done. `busy`=0 while `done`=1.
- Back-to-back throughput is one operation per `WORDS`+1 cycles, with start held high continuously.
- Reset mid-operation aborts immediately. All outputs go to reset values, and no `done` pulse is produced.
- Combinational path: carry register -> `cla_adder` -> slice register, with one `cla_adder` delay per cycle.

## Configuration
- `WIDE_ADD_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 at an edge in ADD or DONE forces IDLE, `busy`=0, `done`=0, `sum_out`=0, `cout`=0, `ovf`=0.
  - `abort` has priority over `start` on the same edge. `abort` in IDLE has no effect.
- `WIDE_ADD_ABORT_EN` undefined: the `abort` port does not exist and an operation always runs to completion.

## Test plan
All scenarios use `WORDS`=4.
- Inter-slice carry: A=0x...0000_0000_FFFF_FFFF, B=1, cin=0 -> `sum_out`=0x...0000_0001_0000_0000, `cout`=0, `ovf`=0, `done` exactly 5 cycles after start.
- Full wrap: A=all ones (128-bit), B=1, cin=0 -> `sum_out`=0, `cout`=1, `ovf`=0. Also A=0, B=0, cin=1 -> `sum_out`=1, `cout`=0.
- Signed overflow: A=0x7FFF...FFFF, B=1 -> `sum_out`=0x8000...0000, `ovf`=1, `cout`=0. Also A=0x8000...0000, B=0x8000...0000 -> `sum_out`=0, `ovf`=1, `cout`=1.
- Handshake: pulse `start` again during ADD with different operands -> ignored, and the first result completes. Hold `start` high -> `done` pulses every 5 cycles, and `busy` is low only in DONE cycles.
- Reset mid-op: assert `rst` asynchronously at the second ADD cycle -> all outputs 0 immediately, no `done`. After release, a start with A=5, B=3 yields `sum_out`=8.
- With `WIDE_ADD_ABORT_EN`: `abort` at the third ADD cycle -> IDLE, all outputs 0, no `done`. Abort and start on the same edge in DONE -> IDLE, and the start is not accepted.
